// File: rtl/qrd_result_collector.sv
// qrd_result_collector: captures the staggered QRD row outputs (four R entries
// plus one QHy entry per row) into a 4x5 buffer, then drains the 20 entries in
// row-major order over a valid/ready stream.
module qrd_result_collector #(
  parameter int unsigned DW          = 14,
  parameter int unsigned ROW1_OFS    = 62,
  parameter int unsigned ROW2_OFS    = 82,
  parameter int unsigned ROW34_OFS   = 102,
  parameter int unsigned TIMEOUT_CYC = 127,
  parameter int unsigned CW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          out_valid,
  input  logic [DW-1:0] row_out_1_r,
  input  logic [DW-1:0] row_out_1_i,
  input  logic [DW-1:0] row_out_2_r,
  input  logic [DW-1:0] row_out_2_i,
  input  logic [DW-1:0] row_out_3_r,
  input  logic [DW-1:0] row_out_3_i,
  input  logic [DW-1:0] row_out_4_r,
  input  logic [DW-1:0] row_out_4_i,
  output logic          busy,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_r,
  output logic [DW-1:0] rd_i,
  output logic [1:0]    rd_row,
  output logic [2:0]    rd_col,
  output logic          rd_last,
  output logic          err_missing,
  output logic          err_timeout,
  output logic          start_drop
);

  localparam int unsigned NENT  = 20;
  localparam int unsigned NLANE = 4;
  localparam int unsigned IW    = 5;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [DW-1:0] ent_r [NENT];
  logic [DW-1:0] ent_i [NENT];
  logic [DW-1:0] lane_r [NLANE];
  logic [DW-1:0] lane_i [NLANE];
  logic [NLANE-1:0] win;
  logic [IW-1:0] wr_idx [NLANE];
  logic          cap_done, cap_tout, xfer;
  logic [1:0]    nxt_row;
  logic [2:0]    nxt_col;
  logic [IW-1:0] nxt_idx;
  logic          nxt_last, nxt_zero;

  // Capture window start for each lane; lanes 3 and 4 share a window.
  function automatic int unsigned lane_ofs(input int l);
    case (l)
      0:       return ROW1_OFS;
      1:       return ROW2_OFS;
      default: return ROW34_OFS;
    endcase
  endfunction

  assign lane_r[0] = row_out_1_r;
  assign lane_i[0] = row_out_1_i;
  assign lane_r[1] = row_out_2_r;
  assign lane_i[1] = row_out_2_i;
  assign lane_r[2] = row_out_3_r;
  assign lane_i[2] = row_out_3_i;
  assign lane_r[3] = row_out_4_r;
  assign lane_i[3] = row_out_4_i;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic and frame-level strobes.
  always_comb begin
    state_n  = state;
    cap_done = (state == CAPTURE) && (cnt == CW'(ROW34_OFS + 4));
    cap_tout = (state == CAPTURE) && !cap_done && (cnt == CW'(TIMEOUT_CYC));
    xfer     = (state == DRAIN) && rd_valid && rd_ready;
    case (state)
      IDLE:    if (start) state_n = CAPTURE;
      CAPTURE: begin
        if (cap_done)      state_n = DRAIN;
        else if (cap_tout) state_n = IDLE;
      end
      DRAIN:   if (xfer && rd_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Per-lane capture window decode and buffer write index (row = lane).
  always_comb begin
    win = '0;
    for (int l = 0; l < NLANE; l++) begin
      win[l]    = (state == CAPTURE) && (cnt >= CW'(lane_ofs(l))) &&
                  (cnt <= CW'(lane_ofs(l) + 4));
      wr_idx[l] = IW'(l * 5) + IW'(3'(cnt - CW'(lane_ofs(l))));
    end
  end

  // Next drain entry: (0,0) when leaving CAPTURE, else row-major successor.
  always_comb begin
    nxt_row = rd_row;
    nxt_col = rd_col + 3'd1;
    if (state == CAPTURE) begin
      nxt_row = '0;
      nxt_col = '0;
    end else if (rd_col == 3'd4) begin
      nxt_row = rd_row + 2'd1;
      nxt_col = '0;
    end
    nxt_idx  = IW'(nxt_row) * IW'(5) + IW'(nxt_col);
    nxt_last = (nxt_row == 2'd3) && (nxt_col == 3'd4);
    nxt_zero = (nxt_col < {1'b0, nxt_row});
  end

  // Entry buffer: cleared on frame start, written only on valid window cycles.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int e = 0; e < NENT; e++) begin
        ent_r[e] <= '0;
        ent_i[e] <= '0;
      end
    end else begin
      for (int l = 0; l < NLANE; l++) begin
        if (win[l] && out_valid) begin
          ent_r[wr_idx[l]] <= lane_r[l];
          ent_i[wr_idx[l]] <= lane_i[l];
        end
      end
    end
  end

  // Cycle counter, status flags and the registered drain stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      busy        <= 1'b0;
      start_drop  <= 1'b0;
      err_missing <= 1'b0;
      err_timeout <= 1'b0;
      rd_valid    <= 1'b0;
      rd_r        <= '0;
      rd_i        <= '0;
      rd_row      <= '0;
      rd_col      <= '0;
      rd_last     <= 1'b0;
    end else begin
      cnt        <= (state == CAPTURE) ? cnt + CW'(1) : '0;
      busy       <= (state_n != IDLE);
      start_drop <= start && (state != IDLE);
      if ((|win) && !out_valid) err_missing <= 1'b1;
      if (cap_tout)             err_timeout <= 1'b1;
      if (cap_done || (xfer && !rd_last)) begin
        rd_valid <= 1'b1;
        rd_row   <= nxt_row;
        rd_col   <= nxt_col;
        rd_last  <= nxt_last;
        rd_r     <= nxt_zero ? '0 : ent_r[nxt_idx];
        rd_i     <= nxt_zero ? '0 : ent_i[nxt_idx];
      end else if (xfer) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qrd_result_collector.sv
// tb_qrd_result_collector: randomized frames checked against a row/column
// model of the captured R|QHy matrix.
module tb_qrd_result_collector;

  localparam int DW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, out_valid, rd_ready;
  logic [DW-1:0] dr_r [4];
  logic [DW-1:0] dr_i [4];
  logic          busy, rd_valid, rd_last, err_missing, err_timeout, start_drop;
  logic [DW-1:0] rd_r, rd_i;
  logic [1:0]    rd_row;
  logic [2:0]    rd_col;

  logic          t_start, t_ov, t_rdy;
  logic          t_busy, t_rd_valid, t_rd_last, t_err_missing, t_err_timeout, t_start_drop;
  logic [DW-1:0] t_rd_r, t_rd_i;
  logic [1:0]    t_rd_row;
  logic [2:0]    t_rd_col;

  qrd_result_collector u_dut (
    .clk(clk), .rst(rst), .start(start), .out_valid(out_valid),
    .row_out_1_r(dr_r[0]), .row_out_1_i(dr_i[0]),
    .row_out_2_r(dr_r[1]), .row_out_2_i(dr_i[1]),
    .row_out_3_r(dr_r[2]), .row_out_3_i(dr_i[2]),
    .row_out_4_r(dr_r[3]), .row_out_4_i(dr_i[3]),
    .busy(busy), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_r(rd_r), .rd_i(rd_i), .rd_row(rd_row), .rd_col(rd_col), .rd_last(rd_last),
    .err_missing(err_missing), .err_timeout(err_timeout), .start_drop(start_drop)
  );

  // Misconfigured instance: rows 3/4 window lies beyond the timeout.
  qrd_result_collector #(.ROW34_OFS(130), .TIMEOUT_CYC(127)) u_tout (
    .clk(clk), .rst(rst), .start(t_start), .out_valid(t_ov),
    .row_out_1_r(dr_r[0]), .row_out_1_i(dr_i[0]),
    .row_out_2_r(dr_r[1]), .row_out_2_i(dr_i[1]),
    .row_out_3_r(dr_r[2]), .row_out_3_i(dr_i[2]),
    .row_out_4_r(dr_r[3]), .row_out_4_i(dr_i[3]),
    .busy(t_busy), .rd_valid(t_rd_valid), .rd_ready(t_rdy),
    .rd_r(t_rd_r), .rd_i(t_rd_i), .rd_row(t_rd_row), .rd_col(t_rd_col), .rd_last(t_rd_last),
    .err_missing(t_err_missing), .err_timeout(t_err_timeout), .start_drop(t_start_drop)
  );

  typedef struct {
    int            row;
    int            col;
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    bit            last;
  } ent_t;

  ent_t          obs[$];
  logic [DW-1:0] lv_r [4][5];
  logic [DW-1:0] lv_i [4][5];
  bit            valid_hist [0:127];
  int            tests_run = 0;
  int            tests_failed = 0;
  int            drop_cnt;

  // Model: lane l produces row l; entry (row,col) sampled at ofs(row)+col.
  function automatic int ofs(input int l);
    return (l == 0) ? 62 : (l == 1) ? 82 : 102;
  endfunction

  function automatic logic [DW-1:0] exp_r(input int row, input int col);
    if (col < row) return '0;
    if (!valid_hist[ofs(row) + col]) return '0;
    return lv_r[row][col];
  endfunction

  function automatic logic [DW-1:0] exp_i(input int row, input int col);
    if (col < row) return '0;
    if (!valid_hist[ofs(row) + col]) return '0;
    return lv_i[row][col];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic fill_random();
    for (int l = 0; l < 4; l++)
      for (int c = 0; c < 5; c++) begin
        lv_r[l][c] = DW'($urandom);
        lv_i[l][c] = DW'($urandom);
      end
  endtask

  task automatic fill_nominal();
    for (int c = 0; c < 5; c++) begin
      lv_r[0][c] = DW'(100 + c);
      lv_i[0][c] = DW'(-100 - c);
      lv_r[1][c] = DW'(200 + c);
      lv_i[1][c] = '0;
      lv_r[2][c] = DW'(300 + c);
      lv_i[2][c] = '0;
      lv_r[3][c] = DW'(400 + c);
      lv_i[3][c] = '0;
    end
  endtask

  task automatic begin_frame();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Drives core outputs for cycles 0..106 after start; junk outside windows.
  task automatic capture(input int miss_cyc, input int start2);
    drop_cnt = 0;
    for (int t = 0; t <= 106; t++) begin
      bit inwin;
      inwin = 1'b0;
      for (int l = 0; l < 4; l++) begin
        if (t >= ofs(l) && t <= ofs(l) + 4) begin
          dr_r[l] = lv_r[l][t - ofs(l)];
          dr_i[l] = lv_i[l][t - ofs(l)];
          inwin   = 1'b1;
        end else begin
          dr_r[l] = DW'($urandom);
          dr_i[l] = DW'($urandom);
        end
      end
      out_valid      = (t == miss_cyc) ? 1'b0 : inwin ? 1'b1 : 1'($urandom_range(0, 1));
      valid_hist[t]  = out_valid;
      start          = (t == start2);
      step();
      drop_cnt += int'(start_drop);
    end
    start     = 1'b0;
    out_valid = 1'b0;
  endtask

  // Consumes the drain stream, recording transfers and stall instability.
  task automatic drain(input bit bp, input bit start_first, input int stop_after,
                       output int n_xfer, output int stall_bad, output bit done);
    obs.delete();
    n_xfer = 0;
    stall_bad = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      ent_t held;
      bit   hold, x, lst;
      if (stop_after >= 0 && n_xfer == stop_after) return;
      rd_ready  = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      start     = start_first && (cyc == 0);
      held.row  = int'(rd_row);
      held.col  = int'(rd_col);
      held.r    = rd_r;
      held.i    = rd_i;
      held.last = rd_last;
      hold      = rd_valid && !rd_ready;
      x         = rd_valid && rd_ready;
      lst       = rd_last;
      if (x) begin
        obs.push_back(held);
        n_xfer++;
      end
      step();
      start = 1'b0;
      drop_cnt += int'(start_drop);
      if (hold && (rd_valid !== 1'b1 || int'(rd_row) != held.row || int'(rd_col) != held.col ||
                   rd_r !== held.r || rd_i !== held.i || rd_last !== held.last))
        stall_bad++;
      if (x && lst) done = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    tests_run++; if ({err_missing, err_timeout, start_drop} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b want 000", {err_missing, err_timeout, start_drop}); end
    tests_run++; if ({rd_r, rd_i, rd_row, rd_col, rd_last} !== '0) begin tests_failed++; $display("FAIL reset_rd_fields got %h want 0", {rd_r, rd_i, rd_row, rd_col, rd_last}); end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int n, sb;
    bit dn;
    do_reset();
    fill_nominal();
    begin_frame();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL nom_busy_capture got %b want 1", busy); end
    capture(-1, -1);
    tests_run++; if (rd_valid !== 1'b1 || rd_row !== 2'd0 || rd_col !== 3'd0) begin tests_failed++; $display("FAIL nom_first_drain got v=%b (%0d,%0d) want v=1 (0,0)", rd_valid, rd_row, rd_col); end
    drain(1'b0, 1'b0, -1, n, sb, dn);
    tests_run++; if (!dn || n != 20) begin tests_failed++; $display("FAIL nom_count got %0d done=%0b want 20 done=1", n, dn); end
    foreach (obs[k]) begin
      tests_run++;
      if (obs[k].row != k / 5 || obs[k].col != k % 5 || obs[k].r !== exp_r(k / 5, k % 5) ||
          obs[k].i !== exp_i(k / 5, k % 5) || obs[k].last != (k == 19)) begin
        tests_failed++;
        $display("FAIL nom_entry%0d got (%0d,%0d) %0d/%0d last=%0b want (%0d,%0d) %0d/%0d last=%0b", k,
                 obs[k].row, obs[k].col, $signed(obs[k].r), $signed(obs[k].i), obs[k].last,
                 k / 5, k % 5, $signed(exp_r(k / 5, k % 5)), $signed(exp_i(k / 5, k % 5)), k == 19);
      end
    end
    if (obs.size() == 20) begin
      tests_run++; if (obs[2].r !== DW'(102) || obs[2].i !== DW'(-102)) begin tests_failed++; $display("FAIL nom_e02 got %0d/%0d want 102/-102", $signed(obs[2].r), $signed(obs[2].i)); end
      tests_run++; if (obs[5].r !== '0 || obs[5].i !== '0) begin tests_failed++; $display("FAIL nom_e10 got %0d/%0d want 0/0", $signed(obs[5].r), $signed(obs[5].i)); end
      tests_run++; if (obs[18].r !== DW'(403)) begin tests_failed++; $display("FAIL nom_e33 got %0d want 403", $signed(obs[18].r)); end
      tests_run++; if (obs[19].r !== DW'(404) || !obs[19].last) begin tests_failed++; $display("FAIL nom_e34 got %0d last=%0b want 404 last=1", $signed(obs[19].r), obs[19].last); end
    end
    tests_run++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL nom_end got v=%b busy=%b want 0 0", rd_valid, busy); end
    tests_run++; if (err_missing !== 1'b0 || err_timeout !== 1'b0) begin tests_failed++; $display("FAIL nom_flags got %b%b want 00", err_missing, err_timeout); end
  endtask

  task automatic test_backpressure();
    int n, sb;
    bit dn;
    do_reset();
    fill_random();
    begin_frame();
    capture(-1, -1);
    drain(1'b1, 1'b0, -1, n, sb, dn);
    tests_run++; if (!dn || n != 20) begin tests_failed++; $display("FAIL bp_count got %0d done=%0b want 20 done=1", n, dn); end
    tests_run++; if (sb != 0) begin tests_failed++; $display("FAIL bp_stall_stable got %0d unstable stalls want 0", sb); end
    foreach (obs[k]) begin
      tests_run++;
      if (obs[k].row != k / 5 || obs[k].col != k % 5 || obs[k].r !== exp_r(k / 5, k % 5) ||
          obs[k].i !== exp_i(k / 5, k % 5) || obs[k].last != (k == 19)) begin
        tests_failed++;
        $display("FAIL bp_entry%0d got (%0d,%0d) %0d/%0d want (%0d,%0d) %0d/%0d", k,
                 obs[k].row, obs[k].col, $signed(obs[k].r), $signed(obs[k].i),
                 k / 5, k % 5, $signed(exp_r(k / 5, k % 5)), $signed(exp_i(k / 5, k % 5)));
      end
    end
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_end got v=%b want 0", rd_valid); end
  endtask

  task automatic test_missing();
    int n, sb;
    bit dn;
    do_reset();
    fill_nominal();
    begin_frame();
    capture(84, -1);
    drain(1'b0, 1'b0, -1, n, sb, dn);
    tests_run++; if (!dn || n != 20) begin tests_failed++; $display("FAIL miss_count got %0d want 20", n); end
    if (obs.size() == 20) begin
      tests_run++; if (obs[7].r !== '0 || obs[7].i !== '0) begin tests_failed++; $display("FAIL miss_e12 got %0d/%0d want 0/0", $signed(obs[7].r), $signed(obs[7].i)); end
    end
    foreach (obs[k]) begin
      tests_run++;
      if (obs[k].r !== exp_r(k / 5, k % 5) || obs[k].i !== exp_i(k / 5, k % 5)) begin
        tests_failed++;
        $display("FAIL miss_entry%0d got %0d/%0d want %0d/%0d", k, $signed(obs[k].r), $signed(obs[k].i),
                 $signed(exp_r(k / 5, k % 5)), $signed(exp_i(k / 5, k % 5)));
      end
    end
    tests_run++; if (err_missing !== 1'b1) begin tests_failed++; $display("FAIL miss_flag got %b want 1", err_missing); end
    // A clean follow-up frame must not clear the sticky flag.
    fill_random();
    begin_frame();
    capture(-1, -1);
    drain(1'b0, 1'b0, -1, n, sb, dn);
    tests_run++; if (err_missing !== 1'b1) begin tests_failed++; $display("FAIL miss_sticky got %b want 1", err_missing); end
    foreach (obs[k]) begin
      tests_run++;
      if (obs[k].r !== exp_r(k / 5, k % 5) || obs[k].i !== exp_i(k / 5, k % 5)) begin
        tests_failed++;
        $display("FAIL miss2_entry%0d got %0d/%0d want %0d/%0d", k, $signed(obs[k].r), $signed(obs[k].i),
                 $signed(exp_r(k / 5, k % 5)), $signed(exp_i(k / 5, k % 5)));
      end
    end
  endtask

  task automatic test_start_during();
    int n, sb;
    bit dn;
    do_reset();
    fill_random();
    begin_frame();
    capture(-1, 70);
    tests_run++; if (drop_cnt != 1) begin tests_failed++; $display("FAIL sd_drop_capture got %0d pulses want 1", drop_cnt); end
    drain(1'b0, 1'b1, -1, n, sb, dn);
    tests_run++; if (drop_cnt != 2) begin tests_failed++; $display("FAIL sd_drop_total got %0d pulses want 2", drop_cnt); end
    tests_run++; if (!dn || n != 20) begin tests_failed++; $display("FAIL sd_count got %0d want 20", n); end
    foreach (obs[k]) begin
      tests_run++;
      if (obs[k].row != k / 5 || obs[k].col != k % 5 ||
          obs[k].r !== exp_r(k / 5, k % 5) || obs[k].i !== exp_i(k / 5, k % 5)) begin
        tests_failed++;
        $display("FAIL sd_entry%0d got (%0d,%0d) %0d/%0d want (%0d,%0d) %0d/%0d", k,
                 obs[k].row, obs[k].col, $signed(obs[k].r), $signed(obs[k].i),
                 k / 5, k % 5, $signed(exp_r(k / 5, k % 5)), $signed(exp_i(k / 5, k % 5)));
      end
    end
    tests_run++; if (busy !== 1'b0 || rd_valid !== 1'b0) begin tests_failed++; $display("FAIL sd_end got busy=%b v=%b want 0 0", busy, rd_valid); end
  endtask

  task automatic test_reset_mid_drain();
    int n, sb, late_valid;
    bit dn;
    do_reset();
    fill_random();
    begin_frame();
    capture(63, -1);
    drain(1'b0, 1'b0, 7, n, sb, dn);
    tests_run++; if (n != 7 || rd_valid !== 1'b1) begin tests_failed++; $display("FAIL rmd_pre got %0d xfers v=%b want 7 v=1", n, rd_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rmd_abort got v=%b busy=%b want 0 0", rd_valid, busy); end
    tests_run++; if (err_missing !== 1'b0 || err_timeout !== 1'b0) begin tests_failed++; $display("FAIL rmd_flags got %b%b want 00", err_missing, err_timeout); end
    late_valid = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      late_valid += int'(rd_valid);
    end
    tests_run++; if (late_valid != 0) begin tests_failed++; $display("FAIL rmd_quiet got %0d valid cycles want 0", late_valid); end
    fill_random();
    begin_frame();
    capture(-1, -1);
    drain(1'b0, 1'b0, -1, n, sb, dn);
    tests_run++; if (!dn || n != 20) begin tests_failed++; $display("FAIL rmd_count got %0d want 20", n); end
    foreach (obs[k]) begin
      tests_run++;
      if (obs[k].row != k / 5 || obs[k].col != k % 5 ||
          obs[k].r !== exp_r(k / 5, k % 5) || obs[k].i !== exp_i(k / 5, k % 5)) begin
        tests_failed++;
        $display("FAIL rmd_entry%0d got (%0d,%0d) %0d/%0d want (%0d,%0d) %0d/%0d", k,
                 obs[k].row, obs[k].col, $signed(obs[k].r), $signed(obs[k].i),
                 k / 5, k % 5, $signed(exp_r(k / 5, k % 5)), $signed(exp_i(k / 5, k % 5)));
      end
    end
  endtask

  task automatic test_timeout();
    int at;
    bit seen, saw_valid;
    at = -1;
    seen = 1'b0;
    saw_valid = 1'b0;
    t_start = 1'b1;
    step();
    t_start = 1'b0;
    for (int n = 1; n <= 200 && !seen; n++) begin
      step();
      if (t_rd_valid) saw_valid = 1'b1;
      if (t_err_timeout) begin
        seen = 1'b1;
        at = n;
      end
    end
    tests_run++; if (at != 128) begin tests_failed++; $display("FAIL tout_cycle got %0d want 128", at); end
    tests_run++; if (t_busy !== 1'b0) begin tests_failed++; $display("FAIL tout_idle got busy=%b want 0", t_busy); end
    for (int c = 0; c < 20; c++) begin
      step();
      if (t_rd_valid) saw_valid = 1'b1;
    end
    tests_run++; if (saw_valid) begin tests_failed++; $display("FAIL tout_no_emit got rd_valid seen=1 want 0"); end
    tests_run++; if (t_err_timeout !== 1'b1) begin tests_failed++; $display("FAIL tout_sticky got %b want 1", t_err_timeout); end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_valid = 1'b0;
    rd_ready  = 1'b1;
    t_start   = 1'b0;
    t_ov      = 1'b1;
    t_rdy     = 1'b1;
    for (int l = 0; l < 4; l++) begin
      dr_r[l] = '0;
      dr_i[l] = '0;
    end
    test_reset();
    test_nominal();
    test_backpressure();
    test_missing();
    test_start_during();
    test_reset_mid_drain();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
